// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_sequencer_pkg;

  // Instruction memory configuration
  localparam int unsigned IMEM_ADDR_W     = 32;
  localparam int unsigned IMEM_DATA_W     = 32;
  localparam logic [31:0] IMEM_WORD_BYTES = 32'd4;

  // Legal fetch window and architectural entry points
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
  localparam logic [31:0] IMEM_END_DEF   = 32'h0000_6FFF;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_addr_check.sv
// Flags fetch addresses that are misaligned or outside the instruction window.
module fetch_addr_check
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] LOW_ADDR  = RESET_PC_DEF,
  parameter logic [31:0] HIGH_ADDR = IMEM_END_DEF
) (
  input  logic [IMEM_ADDR_W-1:0] i_addr,
  output logic                   o_ok
);

  // Word aligned and inside [LOW_ADDR, HIGH_ADDR] inclusive
  always_comb o_ok = (i_addr[1:0] == 2'b00) && (i_addr >= LOW_ADDR) && (i_addr <= HIGH_ADDR);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC owner: one-deep instruction buffer, delay-slot redirects and CP0 flushes.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter logic [31:0] IMEM_END   = IMEM_END_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   npcValid,
  input  logic [IMEM_ADDR_W-1:0] npcTarget,
  input  logic                   excReq,
  input  logic                   eretReq,
  input  logic [IMEM_ADDR_W-1:0] epc,
  output logic                   imemReq,
  output logic [IMEM_ADDR_W-1:0] imemAddr,
  input  logic                   imemAck,
  input  logic [IMEM_DATA_W-1:0] imemRdata,
  output logic                   instrValid,
  output logic [IMEM_DATA_W-1:0] instrOut,
  output logic [IMEM_ADDR_W-1:0] pcOut,
  output logic                   fetchErr
);

  fetch_state_e           r_state, w_nextState;
  logic [IMEM_ADDR_W-1:0] r_reqAddr, w_nextReqAddr;
  logic [IMEM_ADDR_W-1:0] r_drainAddr, w_nextDrainAddr;
  logic [IMEM_DATA_W-1:0] r_instr, w_nextInstr;
  logic [IMEM_ADDR_W-1:0] r_pc, w_nextPc;
  logic                   r_err, w_nextErr;
  logic                   r_pendValid, w_nextPendValid;
  logic [IMEM_ADDR_W-1:0] r_pendTarget, w_nextPendTarget;

  logic                   w_flush;
  logic [IMEM_ADDR_W-1:0] w_flushTarget;
  logic                   w_npcSampled;
  logic                   w_redirValid;
  logic [IMEM_ADDR_W-1:0] w_redirTarget;
  logic [IMEM_ADDR_W-1:0] w_issueAddr;
  logic                   w_addrOk;
  logic                   w_req;

  // Flush source priority, redirect sampling and the address a request would carry
  always_comb begin
    w_flush       = excReq | eretReq;
    w_flushTarget = excReq ? EXC_VECTOR : epc;
    w_npcSampled  = npcValid & ~stall;
    w_redirValid  = w_npcSampled | r_pendValid;
    w_redirTarget = w_npcSampled ? npcTarget : r_pendTarget;
    unique case (r_state)
      FULL:    w_issueAddr = w_npcSampled ? npcTarget : r_reqAddr;
      DRAIN:   w_issueAddr = r_drainAddr;
      default: w_issueAddr = r_reqAddr;
    endcase
  end

  fetch_addr_check #(
    .LOW_ADDR (RESET_PC),
    .HIGH_ADDR(IMEM_END)
  ) u_addrCheck (
    .i_addr(w_issueAddr),
    .o_ok  (w_addrOk)
  );

  // Next-state, buffer and request logic; an illegal address completes at once as an AdEL entry
  always_comb begin
    w_nextState      = r_state;
    w_nextReqAddr    = r_reqAddr;
    w_nextDrainAddr  = r_drainAddr;
    w_nextInstr      = r_instr;
    w_nextPc         = r_pc;
    w_nextErr        = r_err;
    w_nextPendValid  = r_pendValid;
    w_nextPendTarget = r_pendTarget;
    w_req            = 1'b0;
    unique case (r_state)
      FETCH: begin
        w_req = w_addrOk;
        if (w_flush) begin
          w_nextInstr     = '0;
          w_nextErr       = 1'b0;
          w_nextPendValid = 1'b0;
          w_nextReqAddr   = w_flushTarget;
          if (w_addrOk && !imemAck) begin
            w_nextDrainAddr = r_reqAddr;
            w_nextState     = DRAIN;
          end else begin
            w_nextState = FETCH;
          end
        end else if (!w_addrOk || imemAck) begin
          w_nextInstr     = w_addrOk ? imemRdata : '0;
          w_nextErr       = ~w_addrOk;
          w_nextPc        = r_reqAddr;
          w_nextReqAddr   = w_redirValid ? w_redirTarget : r_reqAddr + IMEM_WORD_BYTES;
          w_nextPendValid = 1'b0;
          w_nextState     = FULL;
        end else if (w_npcSampled) begin
          w_nextPendValid  = 1'b1;
          w_nextPendTarget = npcTarget;
        end
      end
      FULL: begin
        if (w_flush) begin
          w_nextInstr     = '0;
          w_nextErr       = 1'b0;
          w_nextPendValid = 1'b0;
          w_nextReqAddr   = w_flushTarget;
          w_nextState     = FETCH;
        end else if (!stall) begin
          w_req = w_addrOk;
          if (!w_addrOk || imemAck) begin
            w_nextInstr   = w_addrOk ? imemRdata : '0;
            w_nextErr     = ~w_addrOk;
            w_nextPc      = w_issueAddr;
            w_nextReqAddr = w_issueAddr + IMEM_WORD_BYTES;
          end else begin
            w_nextReqAddr = w_issueAddr;
            w_nextState   = FETCH;
          end
        end
      end
      DRAIN: begin
        w_req = 1'b1;
        if (w_flush) begin
          w_nextReqAddr = w_flushTarget;
        end
        if (imemAck) begin
          w_nextState = FETCH;
        end
      end
      default: w_nextState = FETCH;
    endcase
  end

  // State, address, buffer and pending-redirect registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= FETCH;
      r_reqAddr    <= RESET_PC;
      r_drainAddr  <= RESET_PC;
      r_instr      <= '0;
      r_pc         <= RESET_PC;
      r_err        <= 1'b0;
      r_pendValid  <= 1'b0;
      r_pendTarget <= '0;
    end else begin
      r_state      <= w_nextState;
      r_reqAddr    <= w_nextReqAddr;
      r_drainAddr  <= w_nextDrainAddr;
      r_instr      <= w_nextInstr;
      r_pc         <= w_nextPc;
      r_err        <= w_nextErr;
      r_pendValid  <= w_nextPendValid;
      r_pendTarget <= w_nextPendTarget;
    end
  end

  // Request is suppressed while reset is held so an in-flight fetch is abandoned
  always_comb begin
    imemReq    = w_req & ~reset;
    imemAddr   = w_issueAddr;
    instrValid = (r_state == FULL);
    instrOut   = r_instr;
    pcOut      = r_pc;
    fetchErr   = r_err;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer with a wait-state instruction memory model.
module tb_fetch_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        npcValid;
  logic [31:0] npcTarget;
  logic        excReq;
  logic        eretReq;
  logic [31:0] epc;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic        instrValid;
  logic [31:0] instrOut;
  logic [31:0] pcOut;
  logic        fetchErr;

  int tests = 0;
  int fails = 0;
  int waits = 0;
  int memCnt = 0;

  typedef struct {
    string       name;
    logic        st;
    logic        nv;
    logic [31:0] nt;
    logic        ex;
    logic        er;
    logic [31:0] ep;
    logic        eReq;
    logic [31:0] eAddr;
    logic        eValid;
    logic [31:0] ePc;
    logic [31:0] eInstr;
    logic        eErr;
  } vec_t;

  vec_t        vecs[$];
  vec_t        sbQ[$];
  logic [31:0] expReqQ[$];
  logic [31:0] expDelQ[$];

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .npcValid(npcValid), .npcTarget(npcTarget),
    .excReq(excReq), .eretReq(eretReq), .epc(epc), .imemReq(imemReq), .imemAddr(imemAddr),
    .imemAck(imemAck), .imemRdata(imemRdata), .instrValid(instrValid), .instrOut(instrOut),
    .pcOut(pcOut), .fetchErr(fetchErr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory acks once a request has been held for `waits` cycles
  assign imemAck   = imemReq && (memCnt == waits);
  assign imemRdata = memWord(imemAddr);

  always @(posedge clk) begin
    if (!imemReq || imemAck) memCnt <= 0;
    else                     memCnt <= memCnt + 1;
  end

  task automatic check32(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic driveIdle();
    stall = 1'b0; npcValid = 1'b0; npcTarget = '0;
    excReq = 1'b0; eretReq = 1'b0; epc = '0;
  endtask

  task automatic doReset();
    driveIdle();
    reset = 1'b1;
    #1;
    check32("reqInReset", {31'd0, imemReq}, 32'd0);
    tick();
    tick();
    #1;
    check32("rstReq",   {31'd0, imemReq},    32'd0);
    check32("rstValid", {31'd0, instrValid}, 32'd0);
    check32("rstPc",    pcOut,               RST_PC);
    check32("rstInstr", instrOut,            32'd0);
    check32("rstErr",   {31'd0, fetchErr},   32'd0);
    reset = 1'b0;
  endtask

  function automatic vec_t mk(input string n, input logic st, input logic nv, input logic [31:0] nt,
                              input logic ex, input logic er, input logic [31:0] ep,
                              input logic eReq, input logic [31:0] eAddr, input logic eValid,
                              input logic [31:0] ePc, input logic [31:0] eInstr, input logic eErr);
    vec_t v;
    v.name = n; v.st = st; v.nv = nv; v.nt = nt; v.ex = ex; v.er = er; v.ep = ep;
    v.eReq = eReq; v.eAddr = eAddr; v.eValid = eValid; v.ePc = ePc; v.eInstr = eInstr; v.eErr = eErr;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    stall = v.st; npcValid = v.nv; npcTarget = v.nt;
    excReq = v.ex; eretReq = v.er; epc = v.ep;
    sbQ.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t v;
    v = sbQ.pop_front();
    check32({v.name, ".req"}, {31'd0, imemReq}, {31'd0, v.eReq});
    if (v.eReq) check32({v.name, ".addr"}, imemAddr, v.eAddr);
    check32({v.name, ".valid"}, {31'd0, instrValid}, {31'd0, v.eValid});
    if (v.eValid) begin
      check32({v.name, ".pc"},    pcOut,             v.ePc);
      check32({v.name, ".instr"}, instrOut,          v.eInstr);
      check32({v.name, ".err"},   {31'd0, fetchErr}, {31'd0, v.eErr});
    end
  endtask

  // Scoreboard: accepted fetches and consumed instructions against expected queues
  task automatic monitorCycle();
    logic [31:0] e;
    if (imemReq && imemAck) begin
      if (expReqQ.size() == 0) check32("unexpectedFetch", imemAddr, 32'hFFFF_FFFF);
      else begin
        e = expReqQ.pop_front();
        check32("fetchAddr", imemAddr, e);
      end
    end
    if (instrValid && !stall) begin
      if (expDelQ.size() == 0) check32("unexpectedDeliver", pcOut, 32'hFFFF_FFFF);
      else begin
        e = expDelQ.pop_front();
        check32("deliverPc",    pcOut,             e);
        check32("deliverInstr", instrOut,          memWord(e));
        check32("deliverErr",   {31'd0, fetchErr}, 32'd0);
      end
    end
  endtask

  task automatic checkQueuesEmpty(input string n);
    check32({n, ".reqLeft"}, expReqQ.size(), 32'd0);
    check32({n, ".delLeft"}, expDelQ.size(), 32'd0);
    expReqQ.delete();
    expDelQ.delete();
  endtask

  initial begin
    reset = 1'b1;
    driveIdle();
    @(negedge clk);
    waits = 0;
    doReset();

    // Zero-wait streaming, delay-slot redirect, stall hold, address faults, flushes
    vecs.push_back(mk("first",     0, 0, 0,            0, 0, 0,     1, 32'h3000, 0, 0, 0, 0));
    vecs.push_back(mk("second",    0, 0, 0,            0, 0, 0,     1, 32'h3004, 1, 32'h3000, memWord(32'h3000), 0));
    vecs.push_back(mk("slotRedir", 0, 1, 32'h3100,     0, 0, 0,     1, 32'h3100, 1, 32'h3004, memWord(32'h3004), 0));
    vecs.push_back(mk("target",    0, 0, 0,            0, 0, 0,     1, 32'h3104, 1, 32'h3100, memWord(32'h3100), 0));
    vecs.push_back(mk("stall1",    1, 0, 0,            0, 0, 0,     0, 0,        1, 32'h3104, memWord(32'h3104), 0));
    vecs.push_back(mk("stallNpc",  1, 1, 32'h3300,     0, 0, 0,     0, 0,        1, 32'h3104, memWord(32'h3104), 0));
    vecs.push_back(mk("resume",    0, 0, 0,            0, 0, 0,     1, 32'h3108, 1, 32'h3104, memWord(32'h3104), 0));
    vecs.push_back(mk("misalign",  0, 1, 32'h3002,     0, 0, 0,     0, 0,        1, 32'h3108, memWord(32'h3108), 0));
    vecs.push_back(mk("overEnd",   0, 1, 32'h7000,     0, 0, 0,     0, 0,        1, 32'h3002, 0, 1));
    vecs.push_back(mk("recover",   0, 1, 32'h3010,     0, 0, 0,     1, 32'h3010, 1, 32'h7000, 0, 1));
    vecs.push_back(mk("lastWord",  0, 1, 32'h6FFC,     0, 0, 0,     1, 32'h6FFC, 1, 32'h3010, memWord(32'h3010), 0));
    vecs.push_back(mk("runOff",    0, 0, 0,            0, 0, 0,     0, 0,        1, 32'h6FFC, memWord(32'h6FFC), 0));
    vecs.push_back(mk("belowLow",  0, 1, 32'h2FFC,     0, 0, 0,     0, 0,        1, 32'h7000, 0, 1));
    vecs.push_back(mk("lowBound",  0, 1, 32'h3000,     0, 0, 0,     1, 32'h3000, 1, 32'h2FFC, 0, 1));
    vecs.push_back(mk("topWord",   0, 1, 32'hFFFF_FFFC,0, 0, 0,     0, 0,        1, 32'h3000, memWord(32'h3000), 0));
    vecs.push_back(mk("wrap",      0, 0, 0,            0, 0, 0,     0, 0,        1, 32'hFFFF_FFFC, 0, 1));
    vecs.push_back(mk("wrapZero",  1, 0, 0,            0, 0, 0,     0, 0,        1, 32'h0, 0, 1));
    vecs.push_back(mk("excInFull", 0, 1, 32'h3000,     1, 0, 0,     0, 0,        1, 32'h0, 0, 1));
    vecs.push_back(mk("excFetch",  0, 0, 0,            0, 0, 0,     1, EXC_PC,   0, 0, 0, 0));
    vecs.push_back(mk("excEret",   0, 0, 0,            1, 1, 32'h3020, 0, 0,     1, EXC_PC, memWord(EXC_PC), 0));
    vecs.push_back(mk("eretAck",   0, 0, 0,            0, 1, 32'h3020, 1, EXC_PC, 0, 0, 0, 0));
    vecs.push_back(mk("eretFetch", 0, 0, 0,            0, 0, 0,     1, 32'h3020, 0, 0, 0, 0));
    vecs.push_back(mk("eretDeliv", 0, 0, 0,            0, 0, 0,     1, 32'h3024, 1, 32'h3020, memWord(32'h3020), 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput();
      tick();
    end

    // 3-wait memory: redirect arrives while the delay slot is still outstanding
    doReset();
    waits = 3;
    expReqQ = '{32'h3000, 32'h3004, 32'h3200, 32'h3204};
    expDelQ = '{32'h3000, 32'h3004, 32'h3200};
    for (int c = 0; c < 16; c++) begin
      driveIdle();
      npcValid  = (c == 5);
      npcTarget = 32'h3200;
      #1;
      if (c == 5) check32("slotInFlight", {31'd0, instrValid}, 32'd0);
      monitorCycle();
      tick();
    end
    checkQueuesEmpty("pendRedir");

    // Exception while a request waits: old request held to ack, data dropped, then vector
    waits = 0;
    doReset();
    expReqQ = '{32'h3000, 32'h3010, EXC_PC};
    expDelQ = '{32'h3000, EXC_PC};
    for (int c = 0; c < 10; c++) begin
      driveIdle();
      if (c == 1) begin
        waits     = 3;
        npcValid  = 1'b1;
        npcTarget = 32'h3010;
      end
      excReq = (c == 3);
      #1;
      if (c == 3 || c == 4) begin
        check32("drainReq",  {31'd0, imemReq}, 32'd1);
        check32("drainAddr", imemAddr,         32'h3010);
      end
      monitorCycle();
      tick();
    end
    checkQueuesEmpty("excDrain");

    // Reset with a request outstanding drops imemReq immediately
    doReset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Owns the fetch PC register and runs the instruction-fetch handshake with instruction memory. It sits at the front of the IF stage. It delivers one instruction at a time to the IF/ID register and applies branch/jump redirects with MIPS delay-slot semantics. It also handles exception-entry and `eret` flushes from CP0. The NPC selection logic feeds it `npcValid`/`npcTarget`; this block decides when that target becomes the next fetch address.

## Interface
- `RESET_PC`, 32'h0000_3000: first fetch address after reset; lower bound of legal fetch range.
- `EXC_VECTOR`, 32'h0000_4180: exception handler entry.
- `IMEM_END`, 32'h0000_6FFF: upper bound (inclusive) of legal fetch range.

Reset is asynchronous and active-high.

- `clk` input 1: clock.
- `reset` input 1: async active-high reset.
- `stall` input 1: hazard unit holds IF/ID.
- `npcValid` input 1: branch taken or jump in ID this cycle.
- `npcTarget` input 32: redirect target.
- `excReq` input 1: exception/interrupt flush pulse from CP0.
- `eretReq` input 1: `eret` flush pulse.
- `epc` input 32: `eret` return address.
- `imemReq` output 1: fetch request.
- `imemAddr` output 32: fetch address, stable while `imemReq` is high.
- `imemAck` input 1: data valid; may arrive in the same cycle as the request.
- `imemRdata` input 32: fetched word.
- `instrValid` output 1: `instrOut` holds a deliverable instruction.
- `instrOut` output 32: instruction to IF/ID.
- `pcOut` output 32: PC of `instrOut`.
- `fetchErr` output 1: AdEL on fetch; `instrOut` is forced to 0 (nop).

## Operation
- State is held in `reqAddr` (address of the request being issued or outstanding), the buffer (`instrOut`, `pcOut`, `fetchErr`), and pending-redirect registers `pendValid`/`pendTarget`.
- **FETCH**:
  - `imemReq`=1, `imemAddr`=`reqAddr`.
  - On `imemAck`: capture into the buffer and go to FULL.
  - At the same time, the next address becomes `pendValid ? pendTarget : reqAddr+4`, and `pendValid` clears.
- **FULL**:
  - `instrValid`=1.
  - The consume cycle is `instrValid && !stall`.
  - On a consume cycle, issue the next request combinationally in the same cycle: `imemReq`=1, `imemAddr` = `npcValid ? npcTarget : reqAddr`.
  - If `imemAck` arrives that cycle, refill the buffer and stay in FULL. Otherwise latch the address into `reqAddr` and go to FETCH.
- **DRAIN**:
  - Keep the old request asserted until `imemAck`, then discard the data and go to FETCH at the flush address.
- **Delay-slot rule**:
  - `npcValid` is sampled only when `!stall`.
  - If consuming that cycle, the consumed instruction is the delay slot and the redirect applies to the fetch issued in the same cycle.
  - If `instrValid`=0 (delay slot still in flight), set `pendValid`/`pendTarget`. The redirect then applies to the fetch following the slot's ack.
- **Address check**:
  - Applies to any issued address with `addr[1:0]`≠0, or `addr` < `RESET_PC`, or `addr` > `IMEM_END`.
  - No memory request is made. Next cycle the block is in FULL with `instrOut`=0, `fetchErr`=1, `pcOut`=`addr`.
- **Flush priority**: `excReq` > `eretReq`. The flush target is `EXC_VECTOR` or `epc`. A flush:
  - clears the buffer and `pendValid`;
  - overrides any redirect and any consume issued in the same cycle;
  - goes to DRAIN if a request is outstanding and `imemAck`=0, otherwise to FETCH.
- The flush target is held in `reqAddr`.
- `eret` has no delay slot.

## Timing
- Reset values:
  - state FETCH, `reqAddr`=`RESET_PC`;
  - `instrValid`=0, `instrOut`=0, `pcOut`=`RESET_PC`, `fetchErr`=0;
  - `pendValid`=0;
  - `imemReq` is forced to 0 while `reset` is high.
- Latency:
  - Zero-wait memory: instruction visible the cycle after the request. Sustained rate is 1 instruction/cycle in FULL.
  - N-wait memory: N+1 cycles per fetch.
- Flush during FETCH with a same-cycle ack: data is discarded and there is no DRAIN.
- A flush during DRAIN updates the target and stays in DRAIN.
- `stall` while FULL: the buffer, `reqAddr` and `pend*` are all held.
- Reset mid-request abandons the request. Memory must tolerate `imemReq` dropping.
- All address arithmetic is 32-bit modulo. 0xFFFF_FFFC+4 wraps to 0, which fails the range check and reports AdEL.

## Structure
- Shared package/include holds:
  - the state encoding (FETCH, FULL, DRAIN, 2 bits);
  - `RESET_PC`, `EXC_VECTOR`, `IMEM_END` defaults, placed beside the existing memory-configuration constants.
- One sub-module is natural: `fetch_addr_check` (combinational range/alignment check).

## Test plan
- Reset release, zero-wait memory, no stall -> requests 0x3000, 0x3004, 0x3008 on consecutive cycles; `instrValid` from cycle 2 onward.
- Branch in ID, delay slot 0x3004 consumed with `npcValid`=1, `npcTarget`=0x3100 -> next request 0x3100; 0x3008 is never requested.
- 3-wait memory, slot still outstanding when `npcValid` arrives with target 0x3200 -> slot delivered, then request 0x3200.
- `excReq` while request 0x3010 is waiting 2 cycles -> `imemReq` holds 0x3010 until ack, data dropped, then request 0x4180; no stale `instrValid`.
- `excReq` and `eretReq` together with `epc`=0x3020 -> next fetch 0x4180. `eretReq` alone -> next fetch 0x3020.
- Redirect to 0x3002, then to 0x7000 -> no `imemReq`; `instrOut`=0, `fetchErr`=1, `pcOut`=0x3002 (and 0x7000 respectively).
